// File: rtl/dcache_refill_unit.sv
// dcache_refill_unit
//   Services read/write misses from the dCache controller by fetching one
//   cache block from memory as a burst of BEATS beats. It then presents the
//   assembled block on the cache write port for one cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   read_repair_request      read-miss request      (missed_raddr)
//   write_repair_request     write-miss request     (missed_waddr)
//   read/write_repair_req_acq  one-cycle accept pulse, read has priority
//   mem_req_*                burst-read request (valid/ready/addr)
//   mem_rsp_*                response beats (valid/data/last)
//   refill_addr/data/mask    block handed to the cache, valid with repair_resolved
//   busy                     high in every state except IDLE
//   proto_err                sticky: mem_rsp_last disagreed with the beat count
//   refill_count             completed refills, saturating
module dcache_refill_unit #(
  parameter int BLOCK_BITS = 1024,
  parameter int BEAT_BITS  = 32,
  parameter int BEATS      = BLOCK_BITS / BEAT_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_repair_request,
  input  logic [31:0]             missed_raddr,
  output logic                    read_repair_req_acq,
  input  logic                    write_repair_request,
  input  logic [31:0]             missed_waddr,
  output logic                    write_repair_req_acq,
  output logic                    repair_resolved,
  output logic [31:0]             refill_addr,
  output logic [BLOCK_BITS-1:0]   refill_data,
  output logic [BLOCK_BITS/8-1:0] refill_mask,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [31:0]             mem_req_addr,
  input  logic                    mem_rsp_valid,
  input  logic [BEAT_BITS-1:0]    mem_rsp_data,
  input  logic                    mem_rsp_last,
  output logic                    busy,
  output logic                    proto_err,
  output logic [15:0]             refill_count
);

  localparam int          CNT_W    = $clog2(BEATS);
  // Clears the byte offset within a block
  localparam logic [31:0] BLK_MASK = ~32'((BLOCK_BITS / 8) - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_beat;
  logic [31:0]             r_addr, r_refill_addr;
  logic [BLOCK_BITS-1:0]   r_data;
  logic [BLOCK_BITS/8-1:0] r_mask;
  logic                    r_rd_acq, r_wr_acq, r_err;
  logic [15:0]             r_refill_count;
  logic                    w_take_rd, w_take_wr, w_beat, w_last_beat;

  always_comb begin
    w_state_nxt = r_state;
    w_take_rd   = 1'b0;
    w_take_wr   = 1'b0;
    w_beat      = 1'b0;
    w_last_beat = (r_beat == CNT_W'(BEATS - 1));
    case (r_state)
      S_IDLE: begin
        // Read wins a tie; the write stays pending and is seen again after DONE
        if (read_repair_request) begin
          w_take_rd   = 1'b1;
          w_state_nxt = S_REQ;
        end else if (write_repair_request) begin
          w_take_wr   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ:  if (mem_req_ready) w_state_nxt = S_FILL;
      S_FILL: begin
        // Only beats seen in FILL are consumed; strays elsewhere are dropped
        w_beat = mem_rsp_valid;
        if (mem_rsp_valid && w_last_beat) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_beat         <= '0;
      r_addr         <= '0;
      r_refill_addr  <= '0;
      r_data         <= '0;
      r_mask         <= '0;
      r_rd_acq       <= 1'b0;
      r_wr_acq       <= 1'b0;
      r_err          <= 1'b0;
      r_refill_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_acq <= w_take_rd;
      r_wr_acq <= w_take_wr;
      if (w_take_rd) r_addr <= missed_raddr & BLK_MASK;
      if (w_take_wr) r_addr <= missed_waddr & BLK_MASK;
      if (w_beat) begin
        r_data[r_beat*BEAT_BITS +: BEAT_BITS] <= mem_rsp_data;
        r_beat <= r_beat + 1'b1;  // wraps to 0 after the final beat
        if (mem_rsp_last != w_last_beat) r_err <= 1'b1;
      end
      // Address is published with the block and held until the next refill
      if (w_state_nxt == S_DONE) r_refill_addr <= r_addr;
      r_mask <= (w_state_nxt == S_DONE) ? '1 : '0;
      if (r_state == S_DONE && r_refill_count != 16'hFFFF)
        r_refill_count <= r_refill_count + 16'd1;
    end
  end

  assign read_repair_req_acq  = r_rd_acq;
  assign write_repair_req_acq = r_wr_acq;
  assign repair_resolved      = (r_state == S_DONE);
  assign refill_addr          = r_refill_addr;
  assign refill_data          = r_data;
  assign refill_mask          = r_mask;
  assign mem_req_valid        = (r_state == S_REQ);
  assign mem_req_addr         = r_addr;
  assign busy                 = (r_state != S_IDLE);
  assign proto_err            = r_err;
  assign refill_count         = r_refill_count;

endmodule

// File: tb/tb_dcache_refill_unit.sv
module tb_dcache_refill_unit;
  localparam int BLOCK_BITS = 1024;
  localparam int BEAT_BITS  = 32;
  localparam int BEATS      = BLOCK_BITS / BEAT_BITS;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    read_repair_request, write_repair_request;
  logic [31:0]             missed_raddr, missed_waddr;
  logic                    read_repair_req_acq, write_repair_req_acq;
  logic                    repair_resolved;
  logic [31:0]             refill_addr;
  logic [BLOCK_BITS-1:0]   refill_data;
  logic [BLOCK_BITS/8-1:0] refill_mask;
  logic                    mem_req_valid, mem_req_ready;
  logic [31:0]             mem_req_addr;
  logic                    mem_rsp_valid, mem_rsp_last;
  logic [BEAT_BITS-1:0]    mem_rsp_data;
  logic                    busy, proto_err;
  logic [15:0]             refill_count;

  dcache_refill_unit #(.BLOCK_BITS(BLOCK_BITS), .BEAT_BITS(BEAT_BITS)) dut (
    .clk(clk), .rst(rst),
    .read_repair_request(read_repair_request), .missed_raddr(missed_raddr),
    .read_repair_req_acq(read_repair_req_acq),
    .write_repair_request(write_repair_request), .missed_waddr(missed_waddr),
    .write_repair_req_acq(write_repair_req_acq),
    .repair_resolved(repair_resolved), .refill_addr(refill_addr),
    .refill_data(refill_data), .refill_mask(refill_mask),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_last(mem_rsp_last),
    .busy(busy), .proto_err(proto_err), .refill_count(refill_count)
  );

  always #5 clk = ~clk;

  // Reference model state: what the cache should be holding and reporting
  int          n_vec = 0, n_bad = 0;
  logic [15:0] exp_count;
  logic        exp_err;
  logic [31:0] exp_addr;
  logic [31:0] exp_words [BEATS];

  typedef struct {
    bit          isw;
    logic [31:0] addr;
    int          rdy;      // cycles mem_req_ready held low
    int          gap;      // max idle cycles before each beat
    int          lastpos;  // beat carrying mem_rsp_last, -1 for none
    bit          seqd;     // beat data = beat index
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name);
    int bad = -1;
    n_vec++;
    for (int k = 0; k < BEATS; k++)
      if (bad < 0 && refill_data[k*BEAT_BITS +: BEAT_BITS] !== exp_words[k]) bad = k;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s word %0d: got %h expected %h", name, bad,
               refill_data[bad*BEAT_BITS +: BEAT_BITS], exp_words[bad]);
    end
  endtask

  task automatic model_reset();
    exp_count = '0;
    exp_err   = 1'b0;
    exp_addr  = '0;
    for (int k = 0; k < BEATS; k++) exp_words[k] = '0;
  endtask

  task automatic chk_cleared(input string tag);
    chk1({tag, " busy"}, busy, 1'b0);
    chk1({tag, " resolved"}, repair_resolved, 1'b0);
    chk1({tag, " mem_req_valid"}, mem_req_valid, 1'b0);
    chk1({tag, " acq"}, read_repair_req_acq | write_repair_req_acq, 1'b0);
    chk1({tag, " proto_err"}, proto_err, 1'b0);
    chk({tag, " count"}, 32'(refill_count), 32'd0);
    chk({tag, " refill_addr"}, refill_addr, 32'd0);
    chk1({tag, " mask"}, |refill_mask, 1'b0);
    chk_data({tag, " data"});
  endtask

  task automatic start_req(input bit isw, input logic [31:0] addr);
    @(negedge clk);
    if (isw) begin write_repair_request = 1'b1; missed_waddr = addr; end
    else     begin read_repair_request  = 1'b1; missed_raddr = addr; end
    @(negedge clk);
    chk1("rd_acq", read_repair_req_acq, !isw);
    chk1("wr_acq", write_repair_req_acq, isw);
    chk1("mem_req_valid", mem_req_valid, 1'b1);
    chk("mem_req_addr", mem_req_addr, addr & 32'hFFFF_FF80);
    read_repair_request  = 1'b0;
    write_repair_request = 1'b0;
  endtask

  // Drives the REQ handshake and the beats; abort_at >= 0 fires rst with that beat
  task automatic serve(input logic [31:0] addr, input int rdy, input int gap,
                       input int lastpos, input bit seqd, input int abort_at);
    logic [31:0] ea = addr & 32'hFFFF_FF80;
    logic [31:0] nw [BEATS];
    for (int d = 0; d < rdy; d++) begin
      // Stray beats while waiting for ready must be ignored
      mem_rsp_valid = 1'b1; mem_rsp_data = $urandom; mem_rsp_last = 1'b1;
      @(negedge clk);
      chk1("acq one-shot", read_repair_req_acq | write_repair_req_acq, 1'b0);
      chk1("req held", mem_req_valid, 1'b1);
      chk("req addr stable", mem_req_addr, ea);
    end
    mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
    if (rdy > 0) begin
      chk_data("stray beat ignored");
      chk1("stray no err", proto_err, exp_err);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      int g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
      mem_rsp_valid = 1'b0;
      repeat (g) @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = seqd ? 32'(k) : $urandom;
      mem_rsp_last  = (k == lastpos);
      nw[k] = mem_rsp_data;
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_cleared("abort");
        // Beats still in flight from the aborted burst
        for (int j = 0; j < 3; j++) begin
          mem_rsp_data = $urandom; mem_rsp_last = (j == 2);
          @(negedge clk);
        end
        mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
        chk_cleared("post-abort");
        return;
      end
      @(negedge clk);
      if (k < BEATS - 1) chk1("no early resolve", repair_resolved, 1'b0);
    end
    mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
    for (int k = 0; k < BEATS; k++) exp_words[k] = nw[k];
    exp_addr  = ea;
    exp_err   = exp_err | (lastpos != BEATS - 1);
    exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'd1;
    chk1("resolved", repair_resolved, 1'b1);
    chk("refill_addr", refill_addr, exp_addr);
    chk1("mask ones", &refill_mask, 1'b1);
    chk_data("refill_data");
    chk1("proto_err", proto_err, exp_err);
    chk1("busy done", busy, 1'b1);
    chk1("acq in done", read_repair_req_acq | write_repair_req_acq, 1'b0);
    @(negedge clk);
    chk1("resolved one cycle", repair_resolved, 1'b0);
    chk1("busy idle", busy, 1'b0);
    chk1("acq in idle", read_repair_req_acq | write_repair_req_acq, 1'b0);
    chk("count", 32'(refill_count), 32'(exp_count));
    chk("addr held", refill_addr, exp_addr);
    chk_data("data held");
    chk1("err sticky", proto_err, exp_err);
  endtask

  initial begin
    tbl[0] = '{isw: 1'b0, addr: 32'h0000_1234, rdy: 0, gap: 0, lastpos: 31, seqd: 1'b1};
    tbl[1] = '{isw: 1'b1, addr: 32'h8000_00FF, rdy: 2, gap: 3, lastpos: 31, seqd: 1'b0};
    tbl[2] = '{isw: 1'b0, addr: 32'hDEAD_BEEF, rdy: 5, gap: 4, lastpos: 31, seqd: 1'b0};
    tbl[3] = '{isw: 1'b1, addr: 32'h0000_007F, rdy: 0, gap: 2, lastpos: 31, seqd: 1'b0};
    tbl[4] = '{isw: 1'b0, addr: 32'h0000_4000, rdy: 1, gap: 1, lastpos: 10, seqd: 1'b0};
    tbl[5] = '{isw: 1'b0, addr: 32'h0000_5000, rdy: 0, gap: 0, lastpos: 31, seqd: 1'b0};

    rst = 1'b1;
    read_repair_request = 1'b0; write_repair_request = 1'b0;
    missed_raddr = '0; missed_waddr = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0; mem_rsp_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_cleared("reset");

    for (int i = 0; i < 6; i++) begin
      start_req(tbl[i].isw, tbl[i].addr);
      serve(tbl[i].addr, tbl[i].rdy, tbl[i].gap, tbl[i].lastpos, tbl[i].seqd, -1);
    end

    // Abort at beat 15, then a normal read completes from a clean slate
    start_req(1'b0, 32'h0000_3300);
    serve(32'h0000_3300, 0, 1, 31, 1'b0, 15);
    start_req(1'b0, 32'h0000_3380);
    serve(32'h0000_3380, 0, 0, 31, 1'b0, -1);

    // Simultaneous read and write: read first, write after returning to IDLE
    @(negedge clk);
    read_repair_request = 1'b1;  missed_raddr = 32'h0000_0100;
    write_repair_request = 1'b1; missed_waddr = 32'h0000_2000;
    @(negedge clk);
    chk1("tie rd_acq", read_repair_req_acq, 1'b1);
    chk1("tie wr_acq", write_repair_req_acq, 1'b0);
    chk("tie addr rd", mem_req_addr, 32'h0000_0100);
    read_repair_request = 1'b0;
    serve(32'h0000_0100, 1, 1, 31, 1'b0, -1);
    @(negedge clk);
    chk1("tie wr_acq late", write_repair_req_acq, 1'b1);
    chk1("tie rd_acq late", read_repair_req_acq, 1'b0);
    chk("tie addr wr", mem_req_addr, 32'h0000_2000);
    write_repair_request = 1'b0;
    serve(32'h0000_2000, 0, 0, 31, 1'b0, -1);

    // Missing last on the final beat flags an error
    chk1("err clear before", proto_err, 1'b0);
    start_req(1'b1, 32'h0000_7000);
    serve(32'h0000_7000, 0, 0, -1, 1'b0, -1);

    // Saturation from a preloaded counter
    @(negedge clk);
    force dut.r_refill_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_refill_count;
    exp_count = 16'hFFFE;
    chk("preload", 32'(refill_count), 32'h0000_FFFE);
    for (int i = 0; i < 2; i++) begin
      start_req(1'b0, 32'h0000_9000 + 32'(i * 128));
      serve(32'h0000_9000 + 32'(i * 128), 0, 1, 31, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_refill_unit.md
DCACHE_REFILL_UNIT -- requirements
Module: dcache_refill_unit

Interface
REQ-001 SHALL have parameters: BLOCK_BITS, default 1024, cache block width; BEAT_BITS, default 32, memory beat width; BEATS = BLOCK_BITS/BEAT_BITS, derived value, 32.
REQ-002 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port read_repair_request, input, 1, read-miss request from the dCache controller.
REQ-005 SHALL have port missed_raddr, input, 32, read-miss address.
REQ-006 SHALL have port read_repair_req_acq, output, 1, one-cycle acknowledge of a read miss.
REQ-007 SHALL have port write_repair_request, input, 1, write-miss request.
REQ-008 SHALL have port missed_waddr, input, 32, write-miss address.
REQ-009 SHALL have port write_repair_req_acq, output, 1, one-cycle acknowledge of a write miss.
REQ-010 SHALL have port repair_resolved, output, 1, one-cycle pulse; refill block is valid.
REQ-011 SHALL have ports refill_addr (output, 32), refill_data (output, BLOCK_BITS) and refill_mask (output, BLOCK_BITS/8); these carry the refill block to the cache write port.
REQ-012 SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1) and mem_req_addr (output, 32); these form the burst-read request to memory.
REQ-013 SHALL have ports mem_rsp_valid (input, 1), mem_rsp_data (input, BEAT_BITS) and mem_rsp_last (input, 1); these form the memory response beats.
REQ-014 SHALL have ports busy (output, 1), proto_err (output, 1) and refill_count (output, 16).

Function
REQ-015 SHALL implement FSM states IDLE, REQ, FILL and DONE.
REQ-016 In IDLE with read_repair_request=1, the block SHALL go to REQ next cycle, pulse read_repair_req_acq for that cycle, and latch {missed_raddr[31:7],7'b0}.
REQ-017 In IDLE with only write_repair_request=1, the block SHALL do the same using write_repair_req_acq and missed_waddr.
REQ-018 When both requests are asserted together, the read SHALL win; the write SHALL stay un-acked and be served after DONE if still asserted.
REQ-019 Exactly one acq SHALL pulse per accepted miss, and no acq SHALL pulse outside the IDLE→REQ transition.
REQ-020 In REQ, mem_req_valid SHALL be 1 and mem_req_addr SHALL hold the latched address; both SHALL stay stable until mem_req_ready=1, then the FSM SHALL go to FILL.
REQ-021 In FILL, each mem_rsp_valid beat k (k=0..31, 5-bit counter) SHALL write refill_data[k*BEAT_BITS +: BEAT_BITS].
REQ-022 Gaps between beats (mem_rsp_valid=0) SHALL be tolerated with no timeout.
REQ-023 Completion SHALL be by count: after beat 31 is accepted, the FSM SHALL go to DONE and the counter SHALL wrap to 0.
REQ-024 When mem_rsp_last disagrees with the count (last on beat ≠31, or missing on beat 31), proto_err SHALL set sticky until rst; the fill still completes by count.
REQ-025 mem_rsp_valid outside FILL SHALL be ignored: no data change, no error.
REQ-026 In DONE, repair_resolved SHALL be 1 for exactly one cycle, refill_addr SHALL equal the latched address, and refill_mask SHALL be all ones; the next state SHALL be IDLE.
REQ-027 refill_addr and refill_data SHALL stay stable from DONE until the next FILL beat 0.
REQ-028 refill_count SHALL increment on each DONE and saturate at 16'hFFFF.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 Minimum latency SHALL be: request sampled at cycle N, acq and mem_req_valid at N+1, ready at N+1, beats N+2..N+33, repair_resolved at N+34.

Reset
REQ-031 On rst the block SHALL force state to IDLE and clear the beat counter, proto_err, refill_count, refill_data, refill_addr and refill_mask, all acqs, repair_resolved and mem_req_valid.
REQ-032 rst during REQ or FILL SHALL abort the fill: partial data is discarded, no repair_resolved pulse occurs, and subsequent in-flight beats are ignored.

Verification
REQ-033 Read miss 0x0000_1234, ready at once, 32 back-to-back beats data=k, last on k=31 → acq at N+1; mem_req_addr=0x0000_1200; repair_resolved at N+34; word k=k; mask all ones; refill_count=1.
REQ-034 Read 0x100 and write 0x2000 asserted together, both held until acked → read acq first; write acq the cycle after the first DONE→IDLE; two pulses in order, addrs 0x100 then 0x2000.
REQ-035 mem_req_ready low 5 cycles, then beats with random gaps → mem_req_addr stable throughout; data correct; pulse only after beat 31.
REQ-036 mem_rsp_last on beat 10 → proto_err=1 and remains 1; fill still completes after 32 beats.
REQ-037 rst asserted at beat 15 → outputs zero next cycle, busy=0, no pulse; a new read miss then completes normally.
REQ-038 65536 fills (or forced counter preload 16'hFFFE) → refill_count saturates at 16'hFFFF.
